irq_aggregator: RTL and testbench



---
 rtl/irq_aggregator_if.sv | 23 ++
 rtl/irq_aggregator.sv | 126 ++++++++++++
 tb/tb_irq_aggregator.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/irq_aggregator_if.sv
// rtl/irq_aggregator_if.sv - Avalon-MM register bus bundle for irq_aggregator
//   address    : word address, master to slave
//   chipselect : slave select, master to slave
//   write_n    : active-low write strobe, master to slave
//   writedata  : write data, master to slave
//   readdata   : registered read data, slave to master
interface irq_aggregator_if;
   logic [3:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [15:0] writedata;
   logic [15:0] readdata;

   modport master (
      output address, chipselect, write_n, writedata,
      input  readdata
   );

   modport slave (
      input  address, chipselect, write_n, writedata,
      output readdata
   );
endinterface

// File: rtl/irq_aggregator.sv
// rtl/irq_aggregator.sv - interrupt aggregator with per-line mask, edge latching and priority report
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   irq_in  : interrupt request lines, bit i is source i, active high
//   bus     : Avalon-MM slave register port (address/chipselect/write_n/writedata/readdata)
//   irq     : registered aggregated interrupt to the CPU
module irq_aggregator #(
   parameter int N_IRQ = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [N_IRQ-1:0] irq_in,
   irq_aggregator_if.slave  bus,
   output logic             irq
);

   localparam logic [3:0] A_PENDING  = 4'd0;
   localparam logic [3:0] A_MASK     = 4'd1;
   localparam logic [3:0] A_EDGE_SEL = 4'd2;
   localparam logic [3:0] A_RAW      = 4'd3;
   localparam logic [3:0] A_ACTIVE   = 4'd4;
   localparam logic [3:0] A_HIGHEST  = 4'd5;
   localparam logic [3:0] A_SOFT_SET = 4'd6;
   localparam logic [3:0] A_CTRL     = 4'd7;

   logic [N_IRQ-1:0] irq_s;
   logic [N_IRQ-1:0] irq_prev;
   logic [N_IRQ-1:0] edge_latch;
   logic [N_IRQ-1:0] edge_next;
   logic [N_IRQ-1:0] mask_r;
   logic [N_IRQ-1:0] edge_sel;
   logic             gen;

   logic [N_IRQ-1:0] rise;
   logic [N_IRQ-1:0] pending;
   logic [N_IRQ-1:0] active;
   logic [N_IRQ-1:0] wdata;
   logic [3:0]       hi_idx;
   logic             hi_valid;
   logic [15:0]      rd_mux;

   logic wr_en;
   logic wr_pending;
   logic wr_mask;
   logic wr_edge_sel;
   logic wr_soft_set;
   logic wr_ctrl;

   // Upper writedata bits are deliberately dropped when N_IRQ < 16.
   logic unused_wdata;
   assign unused_wdata = ^bus.writedata;

   assign wr_en       = bus.chipselect && !bus.write_n;
   assign wr_pending  = wr_en && (bus.address == A_PENDING);
   assign wr_mask     = wr_en && (bus.address == A_MASK);
   assign wr_edge_sel = wr_en && (bus.address == A_EDGE_SEL);
   assign wr_soft_set = wr_en && (bus.address == A_SOFT_SET);
   assign wr_ctrl     = wr_en && (bus.address == A_CTRL);
   assign wdata       = bus.writedata[N_IRQ-1:0];

   assign rise    = irq_s & ~irq_prev;
   assign pending = (edge_sel & edge_latch) | (~edge_sel & irq_s);
   assign active  = pending & mask_r;

   // Set beats W1C so an edge arriving during the clear write is never lost.
   // Level lines hold their latch at 0 so a later switch to edge mode starts clean.
   always_comb begin
      edge_next = edge_latch;
      for (int i = 0; i < N_IRQ; i++) begin
         if (edge_sel[i] && (rise[i] || (wr_soft_set && wdata[i])))
            edge_next[i] = 1'b1;
         else if (!edge_sel[i] || (wr_pending && wdata[i]))
            edge_next[i] = 1'b0;
      end
   end

   // Scan downward so the lowest active index is the one left standing.
   always_comb begin
      hi_idx = 4'd0;
      for (int i = N_IRQ - 1; i >= 0; i--) begin
         if (active[i])
            hi_idx = 4'(i);
      end
      hi_valid = |active;
   end

   always_comb begin
      rd_mux = 16'h0000;
      case (bus.address)
         A_PENDING:  rd_mux = 16'(pending);
         A_MASK:     rd_mux = 16'(mask_r);
         A_EDGE_SEL: rd_mux = 16'(edge_sel);
         A_RAW:      rd_mux = 16'(irq_s);
         A_ACTIVE:   rd_mux = 16'(active);
         A_HIGHEST:  rd_mux = hi_valid ? {1'b1, 11'd0, hi_idx} : 16'h0000;
         A_CTRL:     rd_mux = {15'd0, gen};
         default:    rd_mux = 16'h0000;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_s        <= '0;
         irq_prev     <= '0;
         edge_latch   <= '0;
         mask_r       <= '0;
         edge_sel     <= '0;
         gen          <= 1'b0;
         bus.readdata <= 16'h0000;
         irq          <= 1'b0;
      end else begin
         irq_s        <= irq_in;
         irq_prev     <= irq_s;
         edge_latch   <= edge_next;
         if (wr_mask)
            mask_r <= wdata;
         if (wr_edge_sel)
            edge_sel <= wdata;
         if (wr_ctrl)
            gen <= bus.writedata[0];
         bus.readdata <= rd_mux;
         irq          <= gen && hi_valid;
      end
   end

endmodule

// File: tb/tb_irq_aggregator.sv
// tb/tb_irq_aggregator.sv - scoreboard testbench for irq_aggregator
module tb_irq_aggregator;

   typedef struct {
      string       name;
      logic [15:0] exp;
   } item_t;

   logic       clk;
   logic       reset_n;
   logic [3:0] irq_in;
   logic       irq;
   logic       rd_v;
   logic       irq_chk;

   int checks;
   int errors;

   item_t rd_q[$];
   item_t irq_q[$];

   irq_aggregator_if bus_if ();

   irq_aggregator #(.N_IRQ(4)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .irq_in  (irq_in),
      .bus     (bus_if.slave),
      .irq     (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // A read issued in one cycle returns data after the following edge.
   always @(posedge clk) rd_v <= bus_if.chipselect && bus_if.write_n;

   // Monitor: pops the scoreboard whenever a read result or irq sample is due.
   always @(negedge clk) begin
      item_t it;
      if (rd_v) begin
         if (rd_q.size() == 0) begin
            errors++;
            $display("FAIL rd_unexpected: readdata=%h with no expected value", bus_if.readdata);
         end else begin
            it = rd_q.pop_front();
            checks++;
            if (bus_if.readdata !== it.exp) begin
               errors++;
               $display("FAIL %s: readdata=%h expected=%h", it.name, bus_if.readdata, it.exp);
            end
         end
      end
      if (irq_chk) begin
         if (irq_q.size() == 0) begin
            errors++;
            $display("FAIL irq_unexpected: irq=%b with no expected value", irq);
         end else begin
            it = irq_q.pop_front();
            checks++;
            if (irq !== it.exp[0]) begin
               errors++;
               $display("FAIL %s: irq=%b expected=%b", it.name, irq, it.exp[0]);
            end
         end
      end
   end

   task automatic bus_write(input logic [3:0] a, input logic [15:0] d);
      @(posedge clk); #1;
      bus_if.address    = a;
      bus_if.writedata  = d;
      bus_if.chipselect = 1'b1;
      bus_if.write_n    = 1'b0;
      @(posedge clk); #1;
      bus_if.chipselect = 1'b0;
      bus_if.write_n    = 1'b1;
   endtask

   task automatic bus_read(input logic [3:0] a, input logic [15:0] e, input string n);
      item_t it;
      @(posedge clk); #1;
      it.name = n;
      it.exp  = e;
      rd_q.push_back(it);
      bus_if.address    = a;
      bus_if.chipselect = 1'b1;
      bus_if.write_n    = 1'b1;
      @(posedge clk); #1;
      bus_if.chipselect = 1'b0;
   endtask

   // Samples irq at the next falling edge, i.e. the value after the last rising edge.
   task automatic chk_irq(input logic e, input string n);
      item_t it;
      it.name = n;
      it.exp  = {15'd0, e};
      irq_q.push_back(it);
      irq_chk = 1'b1;
      @(negedge clk); #1;
      irq_chk = 1'b0;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      checks  = 0;
      errors  = 0;
      irq_chk = 1'b0;
      irq_in  = 4'h0;
      reset_n = 1'b0;
      bus_if.address    = 4'd0;
      bus_if.chipselect = 1'b0;
      bus_if.write_n    = 1'b1;
      bus_if.writedata  = 16'h0000;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;

      // Reset state
      for (int a = 0; a <= 8; a++)
         bus_read(4'(a), 16'h0000, $sformatf("reset_rd%0d", a));
      step(); chk_irq(1'b0, "reset_irq");

      // Level source on line 0
      bus_write(4'd2, 16'h0000);
      bus_write(4'd1, 16'h0001);
      bus_write(4'd7, 16'h0001);
      step(); irq_in[0] = 1'b1;
      step(); chk_irq(1'b0, "lvl_rise_k1");
      step(); chk_irq(1'b1, "lvl_rise_k2");
      bus_read(4'd5, 16'h8000, "lvl_highest");
      bus_write(4'd0, 16'h0001);
      bus_read(4'd0, 16'h0001, "lvl_w1c_noeffect");
      step(); irq_in[0] = 1'b0;
      step(); chk_irq(1'b1, "lvl_fall_m1");
      step(); chk_irq(1'b0, "lvl_fall_m2");

      // Writes above N_IRQ are dropped; unmapped space is inert
      bus_write(4'd1, 16'hFFFF);
      bus_read(4'd1, 16'h000F, "mask_width");
      bus_write(4'd9, 16'hFFFF);
      bus_read(4'd9, 16'h0000, "unmapped_rd");

      // Edge pulse on line 2
      bus_write(4'd2, 16'h000F);
      step(); irq_in[2] = 1'b1;
      step(); irq_in[2] = 1'b0; chk_irq(1'b0, "edge_p1");
      step(); chk_irq(1'b0, "edge_p2");
      step(); chk_irq(1'b1, "edge_p3");
      bus_read(4'd0, 16'h0004, "edge_pending");
      step(); chk_irq(1'b1, "edge_held");
      bus_write(4'd0, 16'h0004);
      chk_irq(1'b1, "w1c_edge1");
      step(); chk_irq(1'b0, "w1c_edge2");
      bus_read(4'd0, 16'h0000, "edge_cleared");

      // W1C coincides with rise on line 1: set wins
      bus_write(4'd6, 16'h0002);
      bus_read(4'd0, 16'h0002, "soft_set1");
      step(); irq_in[1] = 1'b1;
      bus_write(4'd0, 16'h0002);
      bus_read(4'd0, 16'h0002, "set_beats_w1c");
      step(); chk_irq(1'b1, "set_beats_w1c_irq");
      // Held-high edge line does not re-latch after W1C
      bus_write(4'd0, 16'h0002);
      step(); step();
      bus_read(4'd0, 16'h0000, "edge_held_once");
      irq_in[1] = 1'b0;

      // Level priority, mask and global enable
      bus_write(4'd2, 16'h0000);
      step(); irq_in = 4'h6;
      bus_write(4'd1, 16'h000F);
      bus_read(4'd5, 16'h8001, "prio_f");
      bus_write(4'd1, 16'h000C);
      bus_read(4'd5, 16'h8002, "prio_c");
      step(); chk_irq(1'b1, "prio_irq");
      bus_write(4'd7, 16'h0000);
      bus_read(4'd4, 16'h0004, "gen_off_active");
      step(); chk_irq(1'b0, "gen_off_irq");
      bus_write(4'd1, 16'h0000);
      bus_read(4'd0, 16'h0006, "masked_pending");

      // Soft set ignored on level lines, then async reset
      step(); irq_in = 4'h0;
      bus_write(4'd2, 16'h0008);
      bus_write(4'd6, 16'h0009);
      bus_read(4'd0, 16'h0008, "soft_set_edge_only");
      bus_write(4'd1, 16'h000C);
      bus_write(4'd7, 16'h0001);
      step(); step(); chk_irq(1'b1, "pre_reset_irq");
      step(); reset_n = 1'b0;
      chk_irq(1'b0, "async_reset_irq");
      step(); reset_n = 1'b1;
      bus_read(4'd0, 16'h0000, "post_reset_pending");
      bus_read(4'd1, 16'h0000, "post_reset_mask");
      step(); chk_irq(1'b0, "post_reset_irq");

      // Drain
      for (int i = 0; i < 10 && (rd_q.size() != 0 || irq_q.size() != 0); i++)
         step();
      if (rd_q.size() != 0 || irq_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d reads and %0d irq checks outstanding, expected 0",
                  rd_q.size(), irq_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
